// File: rtl/tiny_dnn_pkg.sv
// rtl/tiny_dnn_pkg.sv - shared types and constants for the tiny_dnn sequencer
package tiny_dnn_pkg;

    localparam int F_SIZE = 1024;
    localparam int ADDR_W = 10;
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(F_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EXEC,
        S_BIAS,
        S_DRAIN1,
        S_DRAIN2,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/tiny_dnn_src_buf.sv
// rtl/tiny_dnn_src_buf.sv - f_size x real source buffer, one write port, registered read-before-write output
module tiny_dnn_src_buf
    import tiny_dnn_pkg::*;
#(
    parameter int f_size = F_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  real               wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output real               rd_data_o
);

    real mem_q [f_size];
    real rd_data_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= 0.0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tiny_dnn_seq.sv
// rtl/tiny_dnn_seq.sv - pass sequencer for tiny_dnn_core; TINY_DNN_SEQ_BIAS_EN adds the BIAS step
module tiny_dnn_seq
    import tiny_dnn_pkg::*;
#(
    parameter int f_size = F_SIZE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_write,
    input  logic [ADDR_W-1:0] src_wa,
    input  real               src_wd,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              init,
    output logic              exec,
    output logic              bias,
    output logic              update,
    output logic [ADDR_W-1:0] ra,
    output real               d,
    input  real               sum_in,
    output real               result,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(f_size - 2);

`ifdef TINY_DNN_SEQ_BIAS_EN
    localparam seq_state_t S_POST_EXEC = S_BIAS;
`else
    localparam seq_state_t S_POST_EXEC = S_DRAIN1;
`endif

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ra_q, ra_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              done_q, done_d;
    real               result_q, result_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ra_q     <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            result_q <= 0.0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            len_q    <= len_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ra_d     = '0;
        len_d    = len_q;
        done_d   = 1'b0;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                end
            end
            S_INIT: begin
                state_d = (len_q == '0) ? S_POST_EXEC : S_EXEC;
            end
            S_EXEC: begin
                // ra walks 0..len_q-1 and is forced back to 0 on exit.
                if (ra_q == len_q - ADDR_W'(1)) begin
                    state_d = S_POST_EXEC;
                end else begin
                    ra_d = ra_q + ADDR_W'(1);
                end
            end
`ifdef TINY_DNN_SEQ_BIAS_EN
            S_BIAS:   state_d = S_DRAIN1;
`endif
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_DONE;
            S_DONE: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = sum_in;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    tiny_dnn_src_buf #(
        .f_size(f_size)
    ) u_src_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en_i  (src_write),
        .wr_addr_i(src_wa),
        .wr_data_i(src_wd),
        .rd_en_i  (state_q == S_EXEC),
        .rd_addr_i(ra_q),
        .rd_data_o(d)
    );

    assign busy   = (state_q != S_IDLE);
    assign init   = (state_q == S_INIT);
    assign exec   = (state_q == S_EXEC);
`ifdef TINY_DNN_SEQ_BIAS_EN
    assign bias   = (state_q == S_BIAS);
`else
    assign bias   = 1'b0;
`endif
    assign update = (state_q == S_DRAIN2);
    assign ra     = ra_q;
    assign result = result_q;
    assign done   = done_q;

endmodule
